// File: rtl/hyperCord_pkg.sv
// Shared constants, state encoding and arctanh table for the hyperbolic CORDIC engine.
package hyperCord_pkg;

  localparam int I_INT_WIDTH = 2;
  localparam int I_FRA_WIDTH = 16;
  localparam int IDWIDTH     = 1 + I_INT_WIDTH + I_FRA_WIDTH;
  localparam int NITER_DEF   = 16;
  localparam int NSTEP       = NITER_DEF + 2;

  localparam int REP0 = 4;
  localparam int REP1 = 13;

  // atanh(2^-i) rounded to 16 fractional bits; entry 0 is unused padding.
  localparam int LUT_FRA = 16;
  localparam int unsigned ATANH_LUT [0:31] = '{
    0, 35999, 16739, 8235, 4101, 2049, 1024, 512,
    256, 128, 64, 32, 16, 8, 4, 2,
    1, 0, 0, 0, 0, 0, 0, 0,
    0, 0, 0, 0, 0, 0, 0, 0
  };

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Rescale a table entry to the requested fractional width (round to nearest).
  function automatic longint atanh_fix(input int idx, input int fra);
    longint base;
    base = 0;
    if (idx >= 0 && idx < 32) base = longint'(ATANH_LUT[idx[4:0]]);
    if (fra >= LUT_FRA) return base <<< (fra - LUT_FRA);
    return (base + (longint'(1) <<< (LUT_FRA - fra - 1))) >>> (LUT_FRA - fra);
  endfunction

endpackage

// File: rtl/hcordic_microrot.sv
// One combinational hyperbolic CORDIC micro-rotation: direction taken from the sign of z.
module hcordic_microrot #(
  parameter int DWIDTH = 19,
  parameter int IW     = 5
) (
  input  logic [DWIDTH-1:0] x,
  input  logic [DWIDTH-1:0] y,
  input  logic [DWIDTH-1:0] z,
  input  logic [IW-1:0]     i,
  input  logic [DWIDTH-1:0] atanh,
  output logic [DWIDTH-1:0] x_nxt,
  output logic [DWIDTH-1:0] y_nxt,
  output logic [DWIDTH-1:0] z_nxt
);

  logic signed [DWIDTH-1:0] x_sh;
  logic signed [DWIDTH-1:0] y_sh;
  logic                     neg;

  always_comb begin
    neg  = z[DWIDTH-1];
    x_sh = $signed(x) >>> i;
    y_sh = $signed(y) >>> i;
    if (neg) begin
      x_nxt = x - y_sh;
      y_nxt = y - x_sh;
      z_nxt = z + atanh;
    end else begin
      x_nxt = x + y_sh;
      y_nxt = y + x_sh;
      z_nxt = z - atanh;
    end
  end

endmodule

// File: rtl/hyper_cordic_iter.sv
// Iterative hyperbolic CORDIC rotation: one micro-rotation per clock, indices 4 and 13 run twice.
module hyper_cordic_iter
  import hyperCord_pkg::*;
#(
  parameter int INT_WIDTH = I_INT_WIDTH,
  parameter int FRA_WIDTH = I_FRA_WIDTH,
  parameter int DWIDTH    = IDWIDTH,
  parameter int NITER     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] xIn,
  input  logic [DWIDTH-1:0] yIn,
  input  logic [DWIDTH-1:0] zIn,
  input  logic              inValid,
  output logic              inReady,
  output logic [DWIDTH-1:0] xOut,
  output logic [DWIDTH-1:0] yOut,
  output logic [DWIDTH-1:0] zOut,
  output logic              outValid,
  input  logic              outReady
);

  localparam int NSTEP_L = NITER + 2;
  localparam int IW      = $clog2(NITER + 2);
  localparam int CW      = $clog2(NSTEP_L);

  state_t            state_q, state_d;
  logic [DWIDTH-1:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [IW-1:0]     i_q, i_d;
  logic [CW-1:0]     step_q, step_d;
  logic              rep_q, rep_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;

  logic [DWIDTH-1:0] rot_x, rot_y, rot_z;
  logic [DWIDTH-1:0] atanh_tbl [NITER+1];

  for (genvar gi = 0; gi <= NITER; gi++) begin : g_lut
    assign atanh_tbl[gi] = DWIDTH'(atanh_fix(gi, FRA_WIDTH));
  end

  hcordic_microrot #(
    .DWIDTH (DWIDTH),
    .IW     (IW)
  ) u_microrot (
    .x     (x_q),
    .y     (y_q),
    .z     (z_q),
    .i     (i_q),
    .atanh (atanh_tbl[i_q]),
    .x_nxt (rot_x),
    .y_nxt (rot_y),
    .z_nxt (rot_z)
  );

  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    z_d         = z_q;
    i_d         = i_q;
    step_d      = step_q;
    rep_d       = rep_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      IDLE: begin
        if (inValid) begin
          x_d        = xIn;
          y_d        = yIn;
          z_d        = zIn;
          i_d        = IW'(1);
          step_d     = '0;
          rep_d      = 1'b0;
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end
      RUN: begin
        x_d = rot_x;
        y_d = rot_y;
        z_d = rot_z;
        // The first visit to a repeat index holds i so the same shift runs again.
        if (!rep_q && (i_q == IW'(REP0) || i_q == IW'(REP1))) begin
          rep_d = 1'b1;
        end else begin
          rep_d = 1'b0;
          i_d   = i_q + IW'(1);
        end
        if (step_q == CW'(NSTEP_L - 1)) begin
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          step_d = step_q + CW'(1);
        end
      end
      DONE: begin
        if (outReady) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      z_q         <= '0;
      i_q         <= '0;
      step_q      <= '0;
      rep_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      z_q         <= z_d;
      i_q         <= i_d;
      step_q      <= step_d;
      rep_q       <= rep_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign xOut     = x_q;
  assign yOut     = y_q;
  assign zOut     = z_q;
  assign inReady  = in_ready_q;
  assign outValid = out_valid_q;

endmodule

// File: tb/tb_hyper_cordic_iter.sv
// Directed bench for hyper_cordic_iter; expected results are the bit-exact Q2.16 values of the
// 18-step schedule (truncating shifts), each within a few LSB of K_h*cosh / K_h*sinh.
module tb_hyper_cordic_iter;
  import hyperCord_pkg::*;

  localparam int DW  = IDWIDTH;
  localparam int TOL = 4;

  logic          clk;
  logic          rst;
  logic [DW-1:0] xIn, yIn, zIn;
  logic          inValid, inReady;
  logic [DW-1:0] xOut, yOut, zOut;
  logic          outValid, outReady;

  int vectors     = 0;
  int miscompares = 0;
  int lat;
  logic saw_valid;

  hyper_cordic_iter dut (
    .clk      (clk),
    .rst      (rst),
    .xIn      (xIn),
    .yIn      (yIn),
    .zIn      (zIn),
    .inValid  (inValid),
    .inReady  (inReady),
    .xOut     (xOut),
    .yOut     (yOut),
    .zOut     (zOut),
    .outValid (outValid),
    .outReady (outReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint sx(input logic [DW-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_tol(input string tag, input longint obs, input longint exp, input int tol);
    logic ok;
    ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    vectors++;
    assert (ok === 1'b1) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d +/-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic drive_word(input longint x, input longint y, input longint z);
    xIn = x[DW-1:0];
    yIn = y[DW-1:0];
    zIn = z[DW-1:0];
  endtask

  // Waits for inReady, presents one word for one accept edge, then counts cycles to outValid.
  task automatic run_word(input longint x, input longint y, input longint z, output int cycles);
    int guard;
    guard = 0;
    while (!inReady && guard < 50) begin
      tick();
      guard++;
    end
    drive_word(x, y, z);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    cycles = 0;
    while (!outValid && cycles < 60) begin
      tick();
      cycles++;
    end
  endtask

  task automatic handshake();
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    inValid  = 1'b0;
    outReady = 1'b0;
    drive_word(0, 0, 0);
    tick();
    tick();
    tick();
    check_eq("reset_xOut", sx(xOut), 0);
    check_eq("reset_yOut", sx(yOut), 0);
    check_eq("reset_zOut", sx(zOut), 0);
    check_eq("reset_inReady", longint'(inReady), 1);
    check_eq("reset_outValid", longint'(outValid), 0);
    rst = 1'b0;
    tick();

    // x=1.0, y=0, z=0.5
    run_word(65536, 0, 32768, lat);
    check_eq("pos_latency", lat, NSTEP);
    check_eq("pos_outValid", longint'(outValid), 1);
    check_tol("pos_x", sx(xOut), 61206, TOL);
    check_tol("pos_y", sx(yOut), 28288, TOL);
    check_tol("pos_z", sx(zOut), 0, 3);
    handshake();
    check_eq("pos_release_inReady", longint'(inReady), 1);
    check_eq("pos_release_outValid", longint'(outValid), 0);

    // x=1.20750 (gain-compensated), y=0, z=-0.5
    run_word(79135, 0, -32768, lat);
    check_eq("neg_latency", lat, NSTEP);
    check_tol("neg_x", sx(xOut), 73900, TOL);
    check_tol("neg_y", sx(yOut), -34151, TOL);
    check_tol("neg_z", sx(zOut), 0, 3);
    handshake();

    // z=0: d=+1 on the first step, repeats at 4 and 13 give exactly 18 steps
    run_word(65536, 0, 0, lat);
    check_eq("zero_latency", lat, NSTEP);
    check_tol("zero_x", sx(xOut), 54270, TOL);
    check_tol("zero_y", sx(yOut), 0, TOL);
    check_tol("zero_z", sx(zOut), 0, 3);

    // Backpressure in DONE with spurious inValid pulses
    for (int c = 0; c < 10; c++) begin
      inValid = c[0];
      drive_word(12345, -2222, 777);
      tick();
      check_eq("bp_outValid", longint'(outValid), 1);
      check_eq("bp_inReady", longint'(inReady), 0);
      check_tol("bp_x", sx(xOut), 54270, TOL);
      check_tol("bp_y", sx(yOut), 0, TOL);
    end
    inValid = 1'b0;
    handshake();
    check_eq("bp_release_inReady", longint'(inReady), 1);
    check_eq("bp_release_outValid", longint'(outValid), 0);

    // Back-to-back: inValid stays high, the second word waits behind the first result
    drive_word(65536, 0, 32768);
    inValid = 1'b1;
    tick();
    drive_word(79135, 0, -32768);
    lat = 0;
    while (!outValid && lat < 60) begin
      tick();
      lat++;
    end
    check_eq("b2b_first_latency", lat, NSTEP);
    check_tol("b2b_first_x", sx(xOut), 61206, TOL);
    check_tol("b2b_first_y", sx(yOut), 28288, TOL);
    outReady = 1'b1;
    tick();
    outReady = 1'b0;
    check_eq("b2b_idle_inReady", longint'(inReady), 1);
    check_eq("b2b_idle_outValid", longint'(outValid), 0);
    tick();
    inValid = 1'b0;
    check_eq("b2b_second_accepted", longint'(inReady), 0);
    lat = 0;
    while (!outValid && lat < 60) begin
      tick();
      lat++;
    end
    check_eq("b2b_second_latency", lat, NSTEP);
    check_tol("b2b_second_x", sx(xOut), 73900, TOL);
    check_tol("b2b_second_y", sx(yOut), -34151, TOL);
    handshake();

    // Reset for 3 cycles mid-RUN aborts the operation
    drive_word(65536, 0, 32768);
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    repeat (3) tick();
    check_eq("abort_xOut", sx(xOut), 0);
    check_eq("abort_yOut", sx(yOut), 0);
    check_eq("abort_zOut", sx(zOut), 0);
    check_eq("abort_inReady", longint'(inReady), 1);
    check_eq("abort_outValid", longint'(outValid), 0);
    rst = 1'b0;
    saw_valid = 1'b0;
    repeat (30) begin
      tick();
      if (outValid) saw_valid = 1'b1;
    end
    check_eq("abort_no_outValid", longint'(saw_valid), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
